// File: rtl/wb_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Holds the default widths, FIFO depth, starvation limit and entry layout.
package wb_pkg;

    localparam int XLEN          = 32;
    localparam int REG_AW        = 5;
    localparam int WB_DEPTH      = 2;
    localparam int WB_STARVE_MAX = 7;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   wd;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of long-latency results awaiting the register-file port.
// Ports: enq_*/deq_i push/pop, kill_* clears entries by rd, chk_addr_i
// hazard query (pending_o), head_* and count_o describe the oldest entry.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int  WIDTH = XLEN,
    parameter int  DEPTH = WB_DEPTH,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enq_i,
    input  logic [REG_AW-1:0] enq_rd_i,
    input  logic [WIDTH-1:0]  enq_wd_i,
    input  logic              deq_i,
    input  logic              kill_i,
    input  logic [REG_AW-1:0] kill_rd_i,
    input  logic [REG_AW-1:0] chk_addr_i,
    output logic              head_valid_o,
    output logic [REG_AW-1:0] head_rd_o,
    output logic [WIDTH-1:0]  head_wd_o,
    output logic [CW-1:0]     count_o,
    output logic              pending_o
);

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [REG_AW-1:0] rd_q [DEPTH];
    logic [WIDTH-1:0]  wd_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              pending;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Kill first, then pop, then push: a result written this cycle
    // is younger than the pipe write and must survive it.
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_i && rd_q[i] == kill_rd_i) begin
                valid_d[i] = 1'b0;
            end
        end
        if (deq_i) begin
            valid_d[rd_ptr_q] = 1'b0;
        end
        if (enq_i) begin
            valid_d[wr_ptr_q] = 1'b1;
        end
        rd_ptr_d = deq_i ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = enq_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q + CW'(enq_i) - CW'(deq_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (enq_i) begin
                rd_q[wr_ptr_q] <= enq_rd_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq_i) begin
            wd_q[wr_ptr_q] <= enq_wd_i;
        end
    end

    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && rd_q[i] == chk_addr_i) begin
                pending = 1'b1;
            end
        end
    end

    assign head_valid_o = valid_q[rd_ptr_q];
    assign head_rd_o    = rd_q[rd_ptr_q];
    assign head_wd_o    = wd_q[rd_ptr_q];
    assign count_o      = count_q;
    assign pending_o    = pending;

endmodule

// File: rtl/wb_arbiter.sv
// Arbitrates the single register-file write port between the in-order
// pipeline (always wins) and a FIFO of long-latency results.
// Ports: pipe_* pipeline writeback, lu_* long-latency handshake,
// chk_addr/chk_pending hazard query, stall_req bubble request,
// we3/ad3/wd3 registered register-file write port.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int  WIDTH      = XLEN,
    parameter int  DEPTH      = WB_DEPTH,
    parameter int  STARVE_MAX = WB_STARVE_MAX,
    localparam int CW         = $clog2(DEPTH + 1),
    localparam int SW         = $clog2(STARVE_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_we,
    input  logic [REG_AW-1:0] pipe_rd,
    input  logic [WIDTH-1:0]  pipe_wd,
    input  logic              lu_valid,
    input  logic [REG_AW-1:0] lu_rd,
    input  logic [WIDTH-1:0]  lu_wd,
    output logic              lu_ready,
    input  logic [REG_AW-1:0] chk_addr,
    output logic              chk_pending,
    output logic              stall_req,
    output logic              we3,
    output logic [REG_AW-1:0] ad3,
    output logic [WIDTH-1:0]  wd3
);

    logic              head_valid;
    logic [REG_AW-1:0] head_rd;
    logic [WIDTH-1:0]  head_wd;
    logic [CW-1:0]     count;
    logic              fifo_pending;
    logic              empty;
    logic              enq, deq;

    logic              we3_q, we3_d;
    logic [REG_AW-1:0] ad3_q, ad3_d;
    logic [WIDTH-1:0]  wd3_q, wd3_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              stall_q, stall_d;

    assign empty    = (count == '0);
    assign lu_ready = (count < CW'(DEPTH));
    // rd=0 results complete the handshake but never take a slot
    assign enq      = lu_valid && lu_ready && (lu_rd != '0);
    // Killed heads leave even while the pipe owns the port
    assign deq      = !empty && (!head_valid || !pipe_we);

    wb_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .enq_i        (enq),
        .enq_rd_i     (lu_rd),
        .enq_wd_i     (lu_wd),
        .deq_i        (deq),
        .kill_i       (pipe_we),
        .kill_rd_i    (pipe_rd),
        .chk_addr_i   (chk_addr),
        .head_valid_o (head_valid),
        .head_rd_o    (head_rd),
        .head_wd_o    (head_wd),
        .count_o      (count),
        .pending_o    (fifo_pending)
    );

    always_comb begin
        we3_d = 1'b0;
        ad3_d = ad3_q;
        wd3_d = wd3_q;
        if (pipe_we) begin
            if (pipe_rd != '0) begin
                we3_d = 1'b1;
                ad3_d = pipe_rd;
                wd3_d = pipe_wd;
            end
        end else if (head_valid) begin
            we3_d = 1'b1;
            ad3_d = head_rd;
            wd3_d = head_wd;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (deq || empty) begin
            starve_d = '0;
        end else if (head_valid && pipe_we &&
                     starve_q != SW'(STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end
        stall_d = (starve_q == SW'(STARVE_MAX)) ||
                  (count == CW'(DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we3_q    <= 1'b0;
            ad3_q    <= '0;
            wd3_q    <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            we3_q    <= we3_d;
            ad3_q    <= ad3_d;
            wd3_q    <= wd3_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    assign we3       = we3_q;
    assign ad3       = ad3_q;
    assign wd3       = wd3_q;
    assign stall_req = stall_q;

    // The output stage still counts as pending until the write lands
    assign chk_pending = (chk_addr != '0) &&
                         ((we3_q && ad3_q == chk_addr) || fifo_pending);

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_we = 1'b0;
    logic [4:0]  pipe_rd = '0;
    logic [31:0] pipe_wd = '0;
    logic        lu_valid = 1'b0;
    logic [4:0]  lu_rd = '0;
    logic [31:0] lu_wd = '0;
    logic        lu_ready;
    logic [4:0]  chk_addr = '0;
    logic        chk_pending;
    logic        stall_req;
    logic        we3;
    logic [4:0]  ad3;
    logic [31:0] wd3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .pipe_we     (pipe_we),
        .pipe_rd     (pipe_rd),
        .pipe_wd     (pipe_wd),
        .lu_valid    (lu_valid),
        .lu_rd       (lu_rd),
        .lu_wd       (lu_wd),
        .lu_ready    (lu_ready),
        .chk_addr    (chk_addr),
        .chk_pending (chk_pending),
        .stall_req   (stall_req),
        .we3         (we3),
        .ad3         (ad3),
        .wd3         (wd3)
    );

    // Reference model: queue of pending results, oldest first
    typedef struct packed {
        logic        v;
        logic [4:0]  rd;
        logic [31:0] wd;
    } ment_t;

    ment_t       mq[$];
    bit          m_we3;
    bit [4:0]    m_ad3;
    bit [31:0]   m_wd3;
    bit          m_stall;
    int          m_starve;

    function automatic void model_reset();
        mq.delete();
        m_we3    = 0;
        m_ad3    = 0;
        m_wd3    = 0;
        m_stall  = 0;
        m_starve = 0;
    endfunction

    function automatic bit m_pend(input bit [4:0] a);
        if (a == 0) return 0;
        if (m_we3 && m_ad3 == a) return 1;
        foreach (mq[i]) if (mq[i].v && mq[i].rd == a) return 1;
        return 0;
    endfunction

    // Drive one cycle of inputs, advance the model, return at negedge
    task automatic step(input bit pw, input bit [4:0] prd,
                        input bit [31:0] pwd, input bit lv,
                        input bit [4:0] lrd, input bit [31:0] lwd);
        int sz;
        bit hv, dq, st_n;
        ment_t e;
        pipe_we  = pw;
        pipe_rd  = prd;
        pipe_wd  = pwd;
        lu_valid = lv;
        lu_rd    = lrd;
        lu_wd    = lwd;
        sz   = mq.size();
        hv   = sz > 0 && mq[0].v;
        dq   = sz > 0 && (!mq[0].v || !pw);
        st_n = (m_starve == 7) || (sz == 2);
        m_we3 = 0;
        if (pw) begin
            if (prd != 0) begin
                m_we3 = 1; m_ad3 = prd; m_wd3 = pwd;
            end
        end else if (hv) begin
            m_we3 = 1; m_ad3 = mq[0].rd; m_wd3 = mq[0].wd;
        end
        if (dq || sz == 0) m_starve = 0;
        else if (hv && pw && m_starve < 7) m_starve++;
        m_stall = st_n;
        if (dq) void'(mq.pop_front());
        if (pw) foreach (mq[i]) if (mq[i].rd == prd) mq[i].v = 0;
        if (lv && sz < 2 && lrd != 0) begin
            e.v = 1; e.rd = lrd; e.wd = lwd;
            mq.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1;
        model_reset();
        #1;
        checks++;
        if (we3 !== 1'b0) begin errors++;
            $display("FAIL rst_we3 got %0h exp 0", we3); end
        checks++;
        if (ad3 !== 5'd0) begin errors++;
            $display("FAIL rst_ad3 got %0h exp 0", ad3); end
        checks++;
        if (wd3 !== 32'd0) begin errors++;
            $display("FAIL rst_wd3 got %0h exp 0", wd3); end
        checks++;
        if (stall_req !== 1'b0) begin errors++;
            $display("FAIL rst_stall got %0h exp 0", stall_req); end
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        chk_addr = 5;
        #1;
        checks++;
        if (lu_ready !== 1'b1) begin errors++;
            $display("FAIL rst_lu_ready got %0h exp 1", lu_ready); end
        checks++;
        if (chk_pending !== 1'b0) begin errors++;
            $display("FAIL rst_pending got %0h exp 0", chk_pending); end
    endtask

    task automatic test_basic();
        step(0, 0, 0, 1, 5, 32'hAAAA5555);
        chk_addr = 5;
        #1;
        checks++;
        if (we3 !== 1'b0) begin errors++;
            $display("FAIL basic_we3_n1 got %0h exp 0", we3); end
        checks++;
        if (chk_pending !== 1'b1) begin errors++;
            $display("FAIL basic_pending got %0h exp 1", chk_pending); end
        checks++;
        if (lu_ready !== 1'b1) begin errors++;
            $display("FAIL basic_ready got %0h exp 1", lu_ready); end
        idle();
        checks++;
        if (we3 !== 1'b1 || ad3 !== 5'd5 || wd3 !== 32'hAAAA5555) begin
            errors++;
            $display("FAIL basic_write got %0h/%0d/%0h exp 1/5/aaaa5555",
                     we3, ad3, wd3);
        end
        idle();
        checks++;
        if (we3 !== 1'b0 || ad3 !== 5'd5) begin errors++;
            $display("FAIL basic_hold got %0h/%0d exp 0/5", we3, ad3); end
    endtask

    task automatic test_priority();
        step(1, 3, 32'h11, 1, 4, 32'h22);
        checks++;
        if (we3 !== 1'b1 || ad3 !== 5'd3 || wd3 !== 32'h11) begin
            errors++;
            $display("FAIL prio_pipe got %0h/%0d/%0h exp 1/3/11",
                     we3, ad3, wd3);
        end
        idle();
        checks++;
        if (we3 !== 1'b1 || ad3 !== 5'd4 || wd3 !== 32'h22) begin
            errors++;
            $display("FAIL prio_lu got %0h/%0d/%0h exp 1/4/22",
                     we3, ad3, wd3);
        end
        idle();
        checks++;
        if (we3 !== 1'b0) begin errors++;
            $display("FAIL prio_idle got %0h exp 0", we3); end
    endtask

    task automatic test_waw_kill();
        bit bad;
        step(1, 1, 32'h1, 1, 7, 32'h77);
        chk_addr = 7;
        #1;
        checks++;
        if (chk_pending !== 1'b1) begin errors++;
            $display("FAIL waw_pend_q got %0h exp 1", chk_pending); end
        step(1, 7, 32'h99, 0, 0, 0);
        checks++;
        if (we3 !== 1'b1 || ad3 !== 5'd7 || wd3 !== 32'h99) begin
            errors++;
            $display("FAIL waw_write got %0h/%0d/%0h exp 1/7/99",
                     we3, ad3, wd3);
        end
        checks++;
        if (chk_pending !== 1'b1) begin errors++;
            $display("FAIL waw_pend_out got %0h exp 1", chk_pending); end
        idle();
        checks++;
        if (chk_pending !== 1'b0) begin errors++;
            $display("FAIL waw_pend_done got %0h exp 0", chk_pending); end
        bad = (we3 === 1'b1);
        for (int i = 0; i < 4; i++) begin
            idle();
            if (we3 === 1'b1 && ad3 === 5'd7 && wd3 === 32'h77) bad = 1;
        end
        checks++;
        if (bad) begin errors++;
            $display("FAIL waw_stale got %0d exp 0", bad); end
    endtask

    task automatic test_starvation();
        step(1, 1, 32'h1, 1, 9, 32'h99);
        for (int k = 1; k <= 10; k++) begin
            step(1, 2, k, 0, 0, 0);
            checks++;
            if (stall_req !== (k >= 8)) begin errors++;
                $display("FAIL starve_k%0d got %0h exp %0h",
                         k, stall_req, (k >= 8));
            end
        end
        idle();
        checks++;
        if (we3 !== 1'b1 || ad3 !== 5'd9 || wd3 !== 32'h99) begin
            errors++;
            $display("FAIL starve_drain got %0h/%0d/%0h exp 1/9/99",
                     we3, ad3, wd3);
        end
        idle();
        checks++;
        if (stall_req !== 1'b0) begin errors++;
            $display("FAIL starve_clear got %0h exp 0", stall_req); end
    endtask

    task automatic test_full();
        step(1, 1, 32'h1, 1, 10, 32'hA);
        step(1, 2, 32'h2, 1, 11, 32'hB);
        checks++;
        if (lu_ready !== 1'b0) begin errors++;
            $display("FAIL full_ready got %0h exp 0", lu_ready); end
        step(1, 3, 32'h3, 1, 12, 32'hC);
        checks++;
        if (stall_req !== 1'b1 || lu_ready !== 1'b0) begin errors++;
            $display("FAIL full_stall got %0h/%0h exp 1/0",
                     stall_req, lu_ready);
        end
        idle();
        checks++;
        if (we3 !== 1'b1 || ad3 !== 5'd10 || wd3 !== 32'hA) begin
            errors++;
            $display("FAIL full_d1 got %0h/%0d/%0h exp 1/10/a",
                     we3, ad3, wd3);
        end
        idle();
        checks++;
        if (we3 !== 1'b1 || ad3 !== 5'd11 || wd3 !== 32'hB) begin
            errors++;
            $display("FAIL full_d2 got %0h/%0d/%0h exp 1/11/b",
                     we3, ad3, wd3);
        end
        idle();
        chk_addr = 12;
        #1;
        checks++;
        if (we3 !== 1'b0 || chk_pending !== 1'b0) begin errors++;
            $display("FAIL full_drop got %0h/%0h exp 0/0",
                     we3, chk_pending);
        end
        step(0, 0, 0, 1, 0, 32'h5);
        checks++;
        if (lu_ready !== 1'b1 || we3 !== 1'b0) begin errors++;
            $display("FAIL rd0_hs got %0h/%0h exp 1/0", lu_ready, we3); end
        idle();
        chk_addr = 0;
        #1;
        checks++;
        if (we3 !== 1'b0 || chk_pending !== 1'b0) begin errors++;
            $display("FAIL rd0_nowe got %0h/%0h exp 0/0",
                     we3, chk_pending);
        end
    endtask

    task automatic test_reset_mid();
        step(1, 1, 32'h1, 1, 13, 32'hD);
        step(1, 2, 32'h2, 1, 14, 32'hE);
        idle();
        checks++;
        if (we3 !== 1'b1 || ad3 !== 5'd13) begin errors++;
            $display("FAIL mid_pre got %0h/%0d exp 1/13", we3, ad3); end
        rst = 1;
        model_reset();
        #1;
        checks++;
        if (we3 !== 1'b0 || ad3 !== 5'd0 || wd3 !== 32'd0 ||
            stall_req !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst got %0h/%0d/%0h/%0h exp 0/0/0/0",
                     we3, ad3, wd3, stall_req);
        end
        @(negedge clk);
        rst = 0;
        chk_addr = 14;
        #1;
        checks++;
        if (lu_ready !== 1'b1 || chk_pending !== 1'b0) begin errors++;
            $display("FAIL mid_rel got %0h/%0h exp 1/0",
                     lu_ready, chk_pending);
        end
        idle();
        checks++;
        if (we3 !== 1'b0) begin errors++;
            $display("FAIL mid_lost got %0h exp 0", we3); end
    endtask

    task automatic test_random();
        bit        pw, lv;
        bit [4:0]  prd, lrd;
        bit [31:0] pwd, lwd;
        for (int n = 0; n < 400; n++) begin
            chk_addr = 5'($urandom_range(0, 7));
            #1;
            checks++;
            if (lu_ready !== (mq.size() < 2)) begin errors++;
                $display("FAIL rnd_ready n%0d got %0h exp %0h",
                         n, lu_ready, (mq.size() < 2));
            end
            checks++;
            if (chk_pending !== m_pend(chk_addr)) begin errors++;
                $display("FAIL rnd_pend n%0d a%0d got %0h exp %0h",
                         n, chk_addr, chk_pending, m_pend(chk_addr));
            end
            pw  = ($urandom_range(0, 99) < 55);
            lv  = ($urandom_range(0, 99) < 50);
            prd = 5'($urandom_range(0, 7));
            lrd = 5'($urandom_range(0, 7));
            pwd = $urandom;
            lwd = $urandom;
            step(pw, prd, pwd, lv, lrd, lwd);
            checks++;
            if (we3 !== m_we3 || ad3 !== m_ad3 || wd3 !== m_wd3) begin
                errors++;
                $display("FAIL rnd_port n%0d got %0h/%0d/%0h exp %0h/%0d/%0h",
                         n, we3, ad3, wd3, m_we3, m_ad3, m_wd3);
            end
            checks++;
            if (stall_req !== m_stall) begin errors++;
                $display("FAIL rnd_stall n%0d got %0h exp %0h",
                         n, stall_req, m_stall);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_waw_kill();
        test_starvation();
        test_full();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
